dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Parametrised byte-addressed data memory with a request/done handshake for the multi-cycle and pipelined CPU labs. It replaces the fixed 128-byte, word-only, zero-latency data memory. It adds byte, halfword and word accesses with sign or zero extension, a configurable wait-state counter that models slow memory, out-of-range detection and optional alignment checking. It sits between the CPU MEM stage (or the multi-cycle control FSM) and the board I/O.

## Interface
- DEPTH_BYTES, 128: memory size in bytes; must be a multiple of 4 and ≤ 1024.
- WAIT_CYCLES, 0: extra wait states per access, 0..15.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- req  in  1  access request; sampled only when busy=0.
- we  in  1  1 = store, 0 = load.
- size  in  2  access size: 00 = byte, 01 = halfword, 10 = word; 11 is an illegal encoding.
- sign_ext  in  1  for loads: 1 = sign-extend, 0 = zero-extend; ignored for word accesses.
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified: byte in [7:0], halfword in [15:0].
- busy  out  1  access in progress; req is ignored while busy=1.
- done  out  1  one-cycle pulse marking access completion.
- rdata  out  32  load result; held until the next done.
- err  out  1  valid with done; the access was rejected.

## Operation
- Storage is DEPTH_BYTES × 8 bits, big-endian.
  - Word at A: mem[A] = bits [31:24], mem[A+3] = bits [7:0].
  - Halfword at A: mem[A] = bits [15:8].
- On reset, every byte i is set to i[7:0]. Outputs on reset: busy=0, done=0, rdata=0, err=0, state IDLE, counter 0.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: on req=1, latch we, size, sign_ext, addr and wdata. Go to WAIT if WAIT_CYCLES>0, else go to DONE. Load counter with WAIT_CYCLES−1.
  - WAIT: decrement the counter. Go to DONE on the edge where the counter equals 0.
  - DONE: done=1 and busy=0. If req=1, accept the new request exactly as in IDLE. Otherwise go to IDLE.
- The access is performed on the edge entering DONE, using the latched operands.
  - Store: write the selected bytes only; other bytes are unchanged.
  - Load: rdata is the extended value, or the full word for size=10.
- err=1 is raised for any of these; the access then makes no memory change and sets rdata=0:
  - addr + bytes − 1 ≥ DEPTH_BYTES, where bytes = 1, 2 or 4 by size;
  - size=11;
  - misalignment, when alignment checking is compiled in.
- Input changes while busy=1 have no effect, because operands are latched at acceptance.
- Reset asserted mid-access aborts the access. No partial write occurs and state returns to IDLE.

## Timing
- Acceptance edge T: req=1 and busy=0 at edge T.
- done is high during the cycle after edge T+WAIT_CYCLES+1−1, i.e. in cycle WAIT_CYCLES+1 counted from T.
- For WAIT_CYCLES=0, done is high in the cycle immediately after T.
- busy is high from the edge after T through the last WAIT cycle. busy is low in the DONE cycle.
- Throughput is one access per WAIT_CYCLES+1 cycles when req is held high.
- rdata and err change only on the edge entering DONE. A store leaves rdata unchanged.
- A load issued in the DONE cycle of a store to the same address returns the stored data, since the write precedes the read.

## Configuration
- DMEM_ALIGN_CHECK_EN
  - Defined: halfword with addr[0]≠0, or word with addr[1:0]≠00, completes with err=1, no write and rdata=0.
  - Undefined: the low address bits are forced to zero (addr[0] for halfword, addr[1:0] for word) before access. err then reports only out-of-range and size=11.

## Structure
- Package dmem_pkg contains:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the FSM state enum;
  - a WAIT_W constant for the counter width (4).
- Sub-module dmem_lane: combinational logic that maps size and addr[1:0] to a byte-enable mask, shifts wdata into the big-endian lanes, and extracts and extends load data. dmem_ctrl holds the FSM, the counter and the storage array.

## Test plan
- Reset, then a word load at 0x00, WAIT_CYCLES=0 → done in the next cycle, rdata=0x00010203, err=0.
- Store word 0xDEADBEEF at 0x10, then load byte at 0x11 with sign_ext=1 → rdata=0xFFFFFFAD. Load byte at 0x11 with sign_ext=0 → rdata=0x000000AD.
- Store halfword 0x1234 at 0x20, then load word at 0x20 → rdata=0x12342223; bytes 0x22 and 0x23 keep their reset values.
- WAIT_CYCLES=3 with req held high for two loads → each done arrives 4 cycles after its acceptance, busy is low only in DONE cycles, and the second access is accepted at the first DONE edge.
- Word load at 0x7E with DEPTH_BYTES=128 → err=1, rdata=0. Word store at 0x7D → err=1 and memory unchanged.
- Word load at 0x05: with DMEM_ALIGN_CHECK_EN → err=1; without → rdata=0x04050607. Separately, assert reset during a WAIT cycle of a store → no bytes modified, busy=0, done=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the byte-addressed data memory.
// Size encodings, FSM states and the latched request bundle.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: big-endian byte-lane steering for one aligned word.
// be[j] enables rword bits [8j+7:8j]; byte offset 0 sits in bits [31:24].
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wlane,
  output logic [31:0] rext
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rword[{~off, 3'b000} +: 8];
  assign rhalf = rword[{~off[1], 4'b0000} +: 16];

  always_comb begin
    be    = '0;
    wlane = '0;
    rext  = '0;
    unique case (1'b1)
      size == SZ_BYTE: begin
        be    = 4'b1000 >> off;
        wlane = {4{wdata[7:0]}};
        rext  = {{24{sign_ext & rbyte[7]}}, rbyte};
      end
      size == SZ_HALF: begin
        be    = off[1] ? 4'b0011 : 4'b1100;
        wlane = {2{wdata[15:0]}};
        rext  = {{16{sign_ext & rhalf[15]}}, rhalf};
      end
      size == SZ_WORD: begin
        be    = 4'b1111;
        wlane = wdata;
        rext  = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressed data memory with req/done handshake and wait states.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned halfword/word accesses.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 128,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_BYTES);

  state_t            state, next;
  logic [WAIT_W-1:0] cnt;
  dmem_req_t         lat, op;
  logic [7:0]        mem [DEPTH_BYTES];

  logic        accept, fire, bad, oor, mis;
  logic [1:0]  span;
  logic [32:0] last;
  logic [AW-3:0] row;
  logic [3:0]  be;
  logic [31:0] rword, wlane, rext;

  assign busy   = state == S_WAIT;
  assign done   = state == S_DONE;
  assign accept = req && (state != S_WAIT);

  // A zero-wait access is performed on its own acceptance edge.
  assign op = (state == S_WAIT) ? lat
            : {we, size, sign_ext, addr, wdata};

  always_comb begin
    next = state;
    unique case (state)
      S_IDLE, S_DONE:
        next = !accept ? S_IDLE
             : (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
      S_WAIT:
        if (cnt == '0) next = S_DONE;
      default: next = S_IDLE;
    endcase
  end

  assign fire = next == S_DONE;

  assign span = (op.size == SZ_WORD) ? 2'd3
              : (op.size == SZ_HALF) ? 2'd1 : 2'd0;
  assign last = {1'b0, op.addr} + 33'(span);
  assign oor  = last >= 33'(DEPTH_BYTES);

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis = ((op.size == SZ_HALF) && op.addr[0])
            || ((op.size == SZ_WORD) && (op.addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  assign bad = oor || mis || (op.size == 2'b11);
  assign row = bad ? '0 : op.addr[AW-1:2];

  assign rword = {mem[{row, 2'd0}], mem[{row, 2'd1}],
                  mem[{row, 2'd2}], mem[{row, 2'd3}]};

  dmem_lane u_lane (
    .size     (op.size),
    .off      (op.addr[1:0]),
    .sign_ext (op.sign_ext),
    .wdata    (op.wdata),
    .rword    (rword),
    .be       (be),
    .wlane    (wlane),
    .rext     (rext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      lat   <= '0;
      rdata <= '0;
      err   <= 1'b0;
      for (int i = 0; i < DEPTH_BYTES; i++)
        mem[AW'(i)] <= 8'(i);
    end else begin
      if (accept) begin
        lat <= op;
        cnt <= WAIT_W'(WAIT_CYCLES - 1);
      end else if (state == S_WAIT) begin
        cnt <= cnt - WAIT_W'(1);
      end
      if (fire) begin
        err <= bad;
        if (bad)         rdata <= '0;
        else if (!op.we) rdata <= rext;
        if (!bad && op.we)
          for (int j = 0; j < 4; j++)
            if (be[j]) mem[{row, 2'(3 - j)}] <= wlane[8*j +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: two instances (0 and 3 wait states) against a byte-array model.
// Directed cases plus random accesses and a final word sweep of both memories.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int DEPTH = 128;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset [2];
  logic        req [2], we [2], sign_ext [2];
  logic [1:0]  size [2];
  logic [31:0] addr [2], wdata [2], rdata [2];
  logic        busy [2], done [2], err [2];

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  mdl [2][DEPTH];
  logic [31:0] exp_rd [2];

  dmem_ctrl #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset[0]), .req(req[0]), .we(we[0]),
    .size(size[0]), .sign_ext(sign_ext[0]), .addr(addr[0]),
    .wdata(wdata[0]), .busy(busy[0]), .done(done[0]),
    .rdata(rdata[0]), .err(err[0])
  );

  dmem_ctrl #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset[1]), .req(req[1]), .we(we[1]),
    .size(size[1]), .sign_ext(sign_ext[1]), .addr(addr[1]),
    .wdata(wdata[1]), .busy(busy[1]), .done(done[1]),
    .rdata(rdata[1]), .err(err[1])
  );

  always #5 clk = ~clk;

  function automatic int wc(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset(input int d);
    for (int i = 0; i < DEPTH; i++) mdl[d][i] = 8'(i);
    exp_rd[d] = '0;
  endtask

  task automatic model(input int d, input bit w, input logic [1:0] sz,
                       input bit sx, input logic [31:0] a,
                       input logic [31:0] wd, output bit e);
    int n, ai, ea;
    logic [31:0] v;
    ai = int'(a);
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    e  = (n == 0) || (ai + n - 1 >= DEPTH) || (ALIGN && (ai % n != 0));
    if (e) begin
      exp_rd[d] = '0;
      return;
    end
    ea = ai - ai % n;
    if (w) begin
      for (int i = 0; i < n; i++)
        mdl[d][ea + i] = 8'(wd >> (8 * (n - 1 - i)));
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(mdl[d][ea + i]);
      if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      exp_rd[d] = v;
    end
  endtask

  task automatic access(input int d, input bit w, input logic [1:0] sz,
                        input bit sx, input logic [31:0] a,
                        input logic [31:0] wd, input string tag);
    bit e;
    int lat;
    model(d, w, sz, sx, a, wd, e);
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; size[d] = sz;
    sign_ext[d] = sx; addr[d] = a; wdata[d] = wd;
    @(posedge clk);
    #1;
    req[d] = 1'b0; we[d] = ~w; size[d] = 2'($urandom);
    addr[d] = $urandom; wdata[d] = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!done[d]) check({tag, " busy"}, 32'(busy[d]), 32'd1);
    end while (!done[d] && lat < 20);
    check({tag, " latency"}, 32'(lat), 32'(wc(d) + 1));
    check({tag, " err"}, 32'(err[d]), 32'(e));
    check({tag, " rdata"}, rdata[d], exp_rd[d]);
  endtask

  initial begin
    bit e;
    logic [31:0] r1, r2;

    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0;
      size[d] = SZ_WORD; sign_ext[d] = 1'b0;
      addr[d] = '0; wdata[d] = '0;
      model_reset(d);
    end
    repeat (3) @(negedge clk);
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset busy", 32'(busy[d]), 32'd0);
      check("reset done", 32'(done[d]), 32'd0);
      check("reset rdata", rdata[d], 32'd0);
      check("reset err", 32'(err[d]), 32'd0);
    end

    access(0, 0, SZ_WORD, 0, 32'h00, 0, "ld w 00");
    check("ld w 00 value", rdata[0], 32'h0001_0203);
    access(0, 1, SZ_WORD, 0, 32'h10, 32'hDEAD_BEEF, "st w 10");
    access(0, 0, SZ_BYTE, 1, 32'h11, 0, "ld b 11 sx");
    check("ld b 11 sx value", rdata[0], 32'hFFFF_FFAD);
    access(0, 0, SZ_BYTE, 0, 32'h11, 0, "ld b 11 zx");
    check("ld b 11 zx value", rdata[0], 32'h0000_00AD);
    access(0, 1, SZ_HALF, 0, 32'h20, 32'h0000_1234, "st h 20");
    access(0, 0, SZ_WORD, 0, 32'h20, 0, "ld w 20");
    check("ld w 20 value", rdata[0], 32'h1234_2223);
    access(0, 0, SZ_WORD, 0, 32'h7E, 0, "ld w 7e");
    check("ld w 7e err", 32'(err[0]), 32'd1);
    access(0, 1, SZ_WORD, 0, 32'h7D, 32'hCAFE_F00D, "st w 7d");
    access(0, 0, SZ_WORD, 0, 32'h7C, 0, "ld w 7c");
    check("ld w 7c value", rdata[0], 32'h7C7D_7E7F);
    access(0, 0, SZ_WORD, 0, 32'h05, 0, "ld w 05");
    check("ld w 05 result", ALIGN ? 32'(err[0]) : rdata[0],
          ALIGN ? 32'd1 : 32'h0405_0607);
    access(0, 0, 2'b11, 0, 32'h08, 0, "size 11");

    // store then load to the same word back-to-back, no wait states
    model(0, 1, SZ_WORD, 0, 32'h40, 32'h89AB_CDEF, e);
    model(0, 0, SZ_WORD, 0, 32'h40, 0, e);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; size[0] = SZ_WORD;
    addr[0] = 32'h40; wdata[0] = 32'h89AB_CDEF;
    @(posedge clk);
    #1 we[0] = 1'b0;
    @(negedge clk);
    check("raw store done", 32'(done[0]), 32'd1);
    check("raw store busy", 32'(busy[0]), 32'd0);
    @(posedge clk);
    #1 req[0] = 1'b0;
    @(negedge clk);
    check("raw load done", 32'(done[0]), 32'd1);
    check("raw load rdata", rdata[0], exp_rd[0]);

    // req held high across two loads with three wait states
    access(1, 1, SZ_WORD, 0, 32'h10, 32'hDEAD_BEEF, "w3 st w 10");
    model(1, 0, SZ_WORD, 0, 32'h08, 0, e);
    r1 = exp_rd[1];
    model(1, 0, SZ_BYTE, 1, 32'h10, 0, e);
    r2 = exp_rd[1];
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; size[1] = SZ_WORD;
    sign_ext[1] = 1'b0; addr[1] = 32'h08;
    @(posedge clk);
    #1;
    size[1] = SZ_BYTE; sign_ext[1] = 1'b1; addr[1] = 32'h10;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 5) req[1] = 1'b0;
      check("b2b done", 32'(done[1]), 32'((k == 4) || (k == 8)));
      check("b2b busy", 32'(busy[1]), 32'((k != 4) && (k != 8)));
      if (k == 4) check("b2b first rdata", rdata[1], r1);
      if (k == 8) check("b2b second rdata", rdata[1], r2);
    end

    // reset during a wait cycle of a store
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; size[1] = SZ_WORD;
    addr[1] = 32'h30; wdata[1] = 32'hA5A5_A5A5;
    @(posedge clk);
    #1 req[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort busy before", 32'(busy[1]), 32'd1);
    reset[1] = 1'b1;
    #1;
    check("abort busy", 32'(busy[1]), 32'd0);
    check("abort done", 32'(done[1]), 32'd0);
    check("abort rdata", rdata[1], 32'd0);
    @(negedge clk);
    reset[1] = 1'b0;
    model_reset(1);
    access(1, 0, SZ_WORD, 0, 32'h30, 0, "post abort ld 30");
    check("post abort value", rdata[1], 32'h3031_3233);

    for (int i = 0; i < 300; i++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      access(i % 2, 1'($urandom), sz, 1'($urandom),
             32'($urandom_range(0, DEPTH + 7)), $urandom, "random");
    end

    for (int d = 0; d < 2; d++)
      for (int a = 0; a < DEPTH; a += 4)
        access(d, 0, SZ_WORD, 0, 32'(a), 0, "sweep");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
